// File: rtl/alu_req_scheduler_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// State encoding, default widths and requester ids.
package alu_req_scheduler_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_OPW   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/alu_req_scheduler_rr_arb2.sv
// Two-way round-robin grant.
// The requester not served last wins a tie.
module rr_arb2
  import alu_req_scheduler_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_served_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  // One-hot grant, suppressed when not enabled
  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      if (req_i[0] && (!req_i[1] || last_served_i == REQ1))
        grant_o = 2'b01;
      else if (req_i[1])
        grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one combinational ALU between two requesters.
// One op in flight: accept, drive ALU, hold response.
module alu_req_scheduler
  import alu_req_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW   = DEF_OPW,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       vld_q, vld_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [1:0]       grant;
  logic             rsp_take;

  rr_arb2 u_arb (
    .req_i         ({req1_valid, req0_valid}),
    .last_served_i (last_q),
    .enable_i      (state_q == IDLE),
    .grant_o       (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = vld_q[0];
  assign rsp1_valid = vld_q[1];
  assign rsp_data   = data_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = cnt_q;

  assign alu_opcode = (state_q == EXEC) ? op_q : '0;
  assign alu_a      = (state_q == EXEC) ? a_q  : '0;
  assign alu_b      = (state_q == EXEC) ? b_q  : '0;

  assign rsp_take = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state: accept, capture ALU result, wait for response take
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant[1]) begin
          owner_d = REQ1;
          op_d    = req1_opcode;
          a_d     = req1_a;
          b_d     = req1_b;
          state_d = EXEC;
        end else if (grant[0]) begin
          owner_d = REQ0;
          op_d    = req0_opcode;
          a_d     = req0_a;
          b_d     = req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d         = alu_result;
        vld_d[owner_q] = 1'b1;
        state_d        = RESP;
      end
      RESP: begin
        if (rsp_take) begin
          vld_d   = 2'b00;
          last_d  = owner_q;
          cnt_d   = cnt_q + CNTW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= REQ0;
      last_q  <= REQ1;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      vld_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed scenarios plus
// random traffic against a transaction-level model.
module tb_alu_req_scheduler;

  localparam int CNTW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1, r0, r1;
  logic [2:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        rdy0, rdy1, rv0, rv1, busy;
  logic [15:0] rsp_data, alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic [CNTW-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: in flight, owner, cycles since accept
  bit          m_busy;
  bit          m_owner;
  int          m_age;
  bit          m_last;
  int          m_count;
  logic [15:0] m_data;
  logic [2:0]  ml_op;
  logic [15:0] ml_a, ml_b;
  int          order[$];

  always #5 clk = ~clk;

  assign alu_res = alu_a + alu_b + {13'd0, alu_op};

  alu_req_scheduler #(.WIDTH(16), .OPW(3), .CNTW(CNTW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (v0),
    .req0_ready (rdy0),
    .req0_opcode(op0),
    .req0_a     (a0),
    .req0_b     (b0),
    .rsp0_valid (rv0),
    .rsp0_ready (r0),
    .req1_valid (v1),
    .req1_ready (rdy1),
    .req1_opcode(op1),
    .req1_a     (a1),
    .req1_b     (b1),
    .rsp1_valid (rv1),
    .rsp1_ready (r1),
    .rsp_data   (rsp_data),
    .alu_opcode (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_res),
    .busy       (busy),
    .op_count   (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit win0();
    return !m_busy && v0 && (!v1 || m_last);
  endfunction

  function automatic bit win1();
    return !m_busy && v1 && (!v0 || !m_last);
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_age   = 0;
    m_last  = 1;
    m_count = 0;
  endtask

  task automatic check_model();
    bit ex;
    ex = m_busy && m_age == 1;
    chk("ready0", rdy0, win0());
    chk("ready1", rdy1, win1());
    chk("alu_a", alu_a, ex ? ml_a : 16'd0);
    chk("alu_b", alu_b, ex ? ml_b : 16'd0);
    chk("alu_op", alu_op, ex ? ml_op : 3'd0);
    chk("rsp0_v", rv0, m_busy && m_age == 2 && !m_owner);
    chk("rsp1_v", rv1, m_busy && m_age == 2 && m_owner);
    if (m_busy && m_age == 2) chk("rsp_data", rsp_data, m_data);
    chk("busy", busy, m_busy);
    chk("op_count", op_count, m_count % (1 << CNTW));
  endtask

  task automatic cyc(input logic iv0, input logic [2:0] io0,
                     input logic [15:0] ia0, input logic [15:0] ib0,
                     input logic iv1, input logic [2:0] io1,
                     input logic [15:0] ia1, input logic [15:0] ib1,
                     input logic ir0, input logic ir1);
    @(negedge clk);
    v0 = iv0; op0 = io0; a0 = ia0; b0 = ib0;
    v1 = iv1; op1 = io1; a1 = ia1; b1 = ib1;
    r0 = ir0; r1 = ir1;
    #1;
    check_model();
  endtask

  // advance model across one rising edge
  task automatic tick();
    bit g0, g1;
    g0 = win0();
    g1 = win1();
    @(posedge clk);
    if (!m_busy) begin
      if (g0 || g1) begin
        m_busy  = 1;
        m_owner = g1;
        m_age   = 1;
        ml_op   = g1 ? op1 : op0;
        ml_a    = g1 ? a1 : a0;
        ml_b    = g1 ? b1 : b0;
        order.push_back(g1 ? 1 : 0);
      end
    end else if (m_age == 1) begin
      m_age  = 2;
      m_data = ml_a + ml_b + {13'd0, ml_op};
    end else if (m_owner ? r1 : r0) begin
      m_busy  = 0;
      m_last  = m_owner;
      m_count = m_count + 1;
    end
    #1;
  endtask

  task automatic rst();
    @(negedge clk);
    v0 = 0; v1 = 0; r0 = 0; r1 = 0;
    reset = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_rv0", rv0, 0);
    chk("rst_rv1", rv1, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    model_reset();
    order.delete();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1;
    v0 = 0; v1 = 0; r0 = 0; r1 = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    model_reset();
    rst();
    chk("rst_data", rsp_data, 0);

    // single op
    cyc(1, 3'b100, 3, 4, 0, 0, 0, 0, 1, 0);
    chk("s_rdy0", rdy0, 1);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("s_alu_a", alu_a, 3);
    chk("s_alu_b", alu_b, 4);
    chk("s_alu_op", alu_op, 3'b100);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("s_rv0", rv0, 1);
    chk("s_data", rsp_data, 11);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("s_busy", busy, 0);
    chk("s_cnt", op_count, 1);
    tick();

    // arbitration: both valid continuously
    rst();
    for (int c = 0; c < 12; c++) begin
      cyc(1, 3'b111, 10, 10, 1, 3'b011, 255, 0, 1, 1);
      if (c == 2) chk("arb_d0", rsp_data, 27);
      if (c == 5) chk("arb_d1", rsp_data, 258);
      tick();
    end
    chk("arb_n", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      chk("arb_order", order[k], k % 2);

    // backpressure on requester 1
    rst();
    cyc(0, 0, 0, 0, 1, 3'b100, 200, 61, 0, 0);
    chk("bp_rdy1", rdy1, 1);
    tick();
    cyc(1, 3'b001, 7, 8, 0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      cyc(1, 3'b001, 7, 8, 0, 0, 0, 0, 0, 0);
      chk("bp_rv1", rv1, 1);
      chk("bp_data", rsp_data, 265);
      chk("bp_rdy0", rdy0, 0);
      chk("bp_rv0", rv0, 0);
      tick();
    end
    cyc(1, 3'b001, 7, 8, 0, 0, 0, 0, 0, 1);
    tick();
    cyc(1, 3'b001, 7, 8, 0, 0, 0, 0, 1, 0);
    chk("bp_acc0", rdy0, 1);
    tick();

    // reset during EXEC
    rst();
    cyc(1, 3'b101, 34, 5, 0, 0, 0, 0, 1, 0);
    tick();
    rst();
    for (int c = 0; c < 3; c++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("rx_rv0", rv0, 0);
      chk("rx_cnt", op_count, 0);
      tick();
    end
    cyc(1, 3'b101, 34, 5, 0, 0, 0, 0, 1, 0);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("rx_data", rsp_data, 44);
    tick();

    // counter wrap, 17 back-to-back ops
    rst();
    for (int k = 1; k <= 17; k++) begin
      for (int c = 0; c < 3; c++) begin
        cyc(1, 3'(k), 16'(k), 16'(2 * k), 0, 0, 0, 0, 1, 0);
        tick();
      end
      if (k == 15) chk("wrap15", op_count, 15);
      if (k == 16) chk("wrap16", op_count, 0);
      if (k == 17) chk("wrap17", op_count, 1);
    end

    // random traffic with one mid-run reset
    rst();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) rst();
      cyc($urandom_range(0, 2) != 0, 3'($urandom),
          16'($urandom), 16'($urandom),
          $urandom_range(0, 2) != 0, 3'($urandom),
          16'($urandom), 16'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one combinational 16-bit ALU (ports Result, opcode, A, B; 3-bit opcode) between two requesters.
- Each requester issues an operation over a valid/ready request handshake and receives the registered ALU result over a valid/ready response handshake.
- Arbitration is round-robin; one operation is in flight at a time.
- Sits between two command sources (e.g. a sequencer and a test/debug port) and the ALU instance.

Parameters:
- WIDTH, 16, operand/result width in bits
- OPW, 3, opcode width in bits
- CNTW, 16, width of the completed-operation counter

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_opcode  input  OPW  requester 0 opcode
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- rsp0_valid  output  1  result available for requester 0
- rsp0_ready  input  1  requester 0 takes result
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b, rsp1_valid, rsp1_ready  same as requester 0, for requester 1
- rsp_data  output  WIDTH  result for whichever rspN_valid is high
- alu_opcode  output  OPW  to ALU opcode
- alu_a  output  WIDTH  to ALU A
- alu_b  output  WIDTH  to ALU B
- alu_result  input  WIDTH  from ALU Result
- busy  output  1  state is not IDLE
- op_count  output  CNTW  number of completed operations; wraps modulo 2^CNTW

Behaviour:
- Reset (async, active-high):
  - state = IDLE, last_served = 1 (requester 0 wins the first tie).
  - All registered outputs are 0: rsp_data, rspN_valid, op_count, busy.
  - Latched opcode/operands and owner are 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester that is not last_served.
  - reqN_ready is combinational and high only for the granted requester; both are low if neither is valid or the state is not IDLE.
  - On acceptance (valid & ready): latch opcode, A, B and owner id; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_opcode/alu_a/alu_b carry the latched values.
  - At the clock edge, alu_result is registered into rsp_data; rsp<owner>_valid is set; go to RESP.
- Outside EXEC, alu_opcode/alu_a/alu_b are driven to 0.
- RESP:
  - rsp<owner>_valid stays high and rsp_data stays stable until rsp<owner>_ready is high.
  - On that edge: clear valid, last_served = owner, op_count += 1, go to IDLE.
  - The other requester's rsp_valid stays 0 throughout.
- Latency: acceptance in cycle N -> ALU driven in cycle N+1 -> rspN_valid high in cycle N+2. If ready is already high, back-to-back operations take 3 cycles each.
- Both requesters valid continuously: grants strictly alternate 0,1,0,1...
- Response backpressure: no new request is accepted until the response completes.
- reqN_valid dropping before acceptance: no effect, nothing latched.
- rspN_ready while rspN_valid is low: ignored.
- Reset mid-operation (EXEC or RESP): the operation is discarded, no response is produced, and everything returns to its reset values.
- op_count at 2^CNTW-1 followed by a completion: wraps to 0.
- Opcode and operands pass through unmodified. The block does not interpret the opcode; any opcode value is legal.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - default WIDTH=16 and OPW=3;
  - requester ids REQ0=1'b0, REQ1=1'b1.
- One sub-module, rr_arb2: a 2-way round-robin grant. Inputs are req[1:0], last_served and enable; output is a one-hot grant[1:0].
- The FSM, operand latches, response register and counter stay in alu_req_scheduler.

Test Plan:
- The bench drives alu_result from a stub equal to alu_a + alu_b + alu_opcode (mod 2^16).
- Reset check: assert reset mid-run -> busy=0, op_count=0, rsp0_valid=rsp1_valid=0 and alu_a=alu_b=alu_opcode=0 immediately, without waiting for a clock edge.
- Single op: req0 with A=3, B=4, opcode=3'b100, rsp0_ready=1 held, accepted in cycle 0.
  - cycle 0: req0_ready=1.
  - cycle 1: alu_a=3, alu_b=4, alu_opcode=3'b100.
  - cycle 2: rsp0_valid=1, rsp_data=11.
  - cycle 3: busy=0, op_count=1.
- Arbitration: after reset, req0 (A=10, B=10, opcode=3'b111) and req1 (A=255, B=0, opcode=3'b011) both valid in the same cycle.
  - req0 is served first with rsp_data=27, then req1 with rsp_data=258.
  - Further simultaneous pairs alternate 0,1.
- Backpressure: req1 A=200, B=61, opcode=3'b100, with rsp1_ready=0 for 5 cycles while req0_valid=1.
  - rsp1_valid held high with rsp_data=265 stable; req0_ready=0 throughout; rsp0_valid=0.
  - When rsp1_ready=1, req0 is accepted in the following cycle.
- Reset during EXEC: req0 A=34, B=5, opcode=3'b101 accepted, reset pulsed in the next cycle -> no rsp0_valid ever, op_count=0, and a subsequent request completes normally.
- Wrap: CNTW=4 build, 17 back-to-back ops -> op_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
